step_controller: RTL
====================

# step_controller

Execution controller sitting directly upstream of the cycle counter and the pipeline. It turns debug-unit commands (RUN, STEP, STOP) into a registered per-cycle enable, `o_step`, that drives both the pipeline stage enables and the cycle counter's step input. When the pipeline reports a fetched HALT instruction, it drains the pipeline for a fixed number of enabled cycles and then freezes in a terminal halted state.

## Interface

- `DRAIN_CYCLES`, default 4: enabled cycles still issued after the HALT-fetch cycle, so the in-flight instructions retire.
- `DW`, default 3: width of the drain counter; must hold `DRAIN_CYCLES`.

- `i_clk` input, 1 bit: single clock, rising edge.
- `i_rst_n` input, 1 bit: asynchronous, active-low reset.
- `i_cmd_valid` input, 1 bit: command present.
- `i_cmd` input, 2 bits: 00 NOP, 01 RUN, 10 STEP, 11 STOP.
- `o_cmd_ready` output, 1 bit: the command is accepted on a cycle where valid and ready are both high.
- `i_halt_fetched` input, 1 bit: the pipeline's IF stage holds a HALT instruction. Meaningful only on cycles where `o_step`=1.
- `o_step` output, 1 bit: registered enable for the pipeline and the cycle counter.
- `o_done` output, 1 bit: one-cycle pulse.
- `o_halted` output, 1 bit: terminal state reached.
- `o_drain_pending` output, 1 bit: HALT has been seen and the drain is not yet finished.
- `o_state` output, 2 bits: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED.

## Operation

**States**

- **IDLE**
  - `o_step`=0, `o_cmd_ready`=1.
  - Accepted RUN goes to RUN.
  - Accepted STEP goes to STEP.
  - STOP and NOP are accepted and ignored.
- **RUN**
  - `o_step`=1 every cycle, `o_cmd_ready`=1.
  - Accepted STOP goes to IDLE.
  - RUN, STEP and NOP are accepted and ignored.
- **STEP**
  - Lasts exactly one cycle with `o_step`=1 and `o_cmd_ready`=0.
  - Always returns to IDLE, with `o_done`=1 on the following cycle.
- **HALTED**
  - `o_step`=0, `o_halted`=1, `o_cmd_ready`=1.
  - All commands are accepted and ignored.
  - Only reset leaves this state.

**Drain logic**

- On a cycle with `o_step`=1 and `i_halt_fetched`=1 while `o_drain_pending`=0: load the counter with `DRAIN_CYCLES` and set pending.
  - The HALT-fetch cycle itself is not counted.
  - `i_halt_fetched` is ignored once pending is set.
- While pending, every cycle with `o_step`=1 decrements the counter. This applies in both RUN and STEP.
- The drain completes on the cycle where the counter is 1 and `o_step`=1:
  - Next state is HALTED, `o_done` pulses, pending clears.
  - This overrides a simultaneous STOP and the normal STEP-to-IDLE transition.
- If `DRAIN_CYCLES`=0, the HALT-fetch cycle itself completes the drain, giving HALTED on the next cycle.
- The counter never wraps. Decrement is blocked at 0.

**Simultaneous events**

- STOP accepted in RUN on the same cycle as the HALT fetch: the drain is loaded, the state goes to IDLE, and pending stays set. Subsequent STEPs or a RUN finish the drain.

**Reset**

- Asserting `i_rst_n` low asynchronously forces IDLE immediately, including mid-RUN or mid-drain:
  - `o_step`=0, `o_done`=0, `o_halted`=0, `o_drain_pending`=0, counter=0, `o_state`=0, `o_cmd_ready`=1.
- Release is synchronous to the next clock edge. The first command can be accepted on that edge.

## Timing

- `o_step`, `o_done`, `o_halted`, the counter and the state are registered.
- `o_cmd_ready` and `o_drain_pending` are decoded from registers. There is no combinational path from inputs to outputs.
- **RUN latency:** accepted at edge t, so `o_step`=1 from cycle t+1.
- **STOP latency:** accepted at edge t, so `o_step`=0 from cycle t+1. The cycle at t still counts.
- **STEP:** accepted at t gives `o_step` high for exactly cycle t+1, and `o_done` high in cycle t+2.
  - Back-to-back STEPs therefore give at most one step every 2 cycles.
- **Halt latency:** with HALT fetched in an enabled cycle h during RUN, `o_step` is high in cycles h+1..h+`DRAIN_CYCLES`.
  - Then `o_halted`=1 and `o_done`=1 in cycle h+`DRAIN_CYCLES`+1.
  - `o_step`=0 from that cycle on.
- The number of `o_step`=1 cycles equals the cycle counter's increment count. Stepping is never skipped or duplicated.

## Test plan

- **Reset then RUN:** reset, then RUN at t=2 and STOP at t=12 → `o_step` high for cycles 3..12 exactly (10 cycles), `o_state` back to 0 at cycle 13, `o_done` never pulses.
- **Three STEPs:** three STEP commands held valid continuously → `o_step` pulses in cycles t+1, t+3, t+5, and `o_done` pulses at t+2, t+4, t+6.
- **RUN drain, `DRAIN_CYCLES`=4:** HALT fetched at cycle 20 → `o_step` high through cycle 24, `o_halted`=1 and `o_done`=1 at cycle 25, and a later RUN is accepted but `o_step` stays 0.
- **STEP-mode drain:** HALT fetched during a STEP cycle with `DRAIN_CYCLES`=2 → `o_drain_pending`=1 and state IDLE; one more STEP gives IDLE, and the next STEP gives HALTED with a single `o_done` pulse.
- **Simultaneous STOP and HALT:** STOP and HALT fetch in the same RUN cycle → state IDLE, pending=1, counter=`DRAIN_CYCLES`. A following RUN finishes the drain in exactly `DRAIN_CYCLES` enabled cycles.
- **Asynchronous reset mid-drain:** assert `i_rst_n` low mid-drain, between clock edges → `o_step` drops immediately, all outputs hit their reset values, and after release a fresh RUN runs normally.

Source files
------------

// File: rtl/step_controller.sv
// Turns RUN/STEP/STOP debug commands into a registered per-cycle enable. On a HALT fetch it drains the pipeline, then freezes.
// All outputs are registered or decoded from registers, one cycle after the command. Commands are only refused while a STEP is executing.
module step_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int DW           = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  output logic       o_cmd_ready,
  input  logic       i_halt_fetched,
  output logic       o_step,
  output logic       o_done,
  output logic       o_halted,
  output logic       o_drain_pending,
  output logic [1:0] o_state
);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          halted_q, halted_d;

  logic cmd_acc;
  logic drain_load;
  logic drain_done;

  assign o_cmd_ready = (state_q != ST_STEP);
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;

  // HALT is only trusted in enabled cycles and only the first one arms the drain.
  assign drain_load = step_q && i_halt_fetched && !pending_q;
  assign drain_done = (drain_load && (DRAIN_CYCLES == 0)) ||
                      (step_q && pending_q && (cnt_q == DW'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;

    if (drain_load) begin
      cnt_d     = DW'(DRAIN_CYCLES);
      pending_d = 1'b1;
    end else if (pending_q && step_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - DW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_acc && (i_cmd == CMD_RUN)) begin
          state_d = ST_RUN;
        end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (cmd_acc && (i_cmd == CMD_STOP)) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP:   state_d = ST_IDLE;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase

    // Drain completion wins over STOP and over the STEP return to IDLE.
    if (drain_done) begin
      state_d   = ST_HALTED;
      pending_d = 1'b0;
    end
  end

  assign step_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
  assign done_d   = drain_done || (state_q == ST_STEP);
  assign halted_d = (state_d == ST_HALTED);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      step_q    <= 1'b0;
      done_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      step_q    <= step_d;
      done_q    <= done_d;
      halted_q  <= halted_d;
    end
  end

  assign o_step          = step_q;
  assign o_done          = done_q;
  assign o_halted        = halted_q;
  assign o_drain_pending = pending_q;
  assign o_state         = state_q;

endmodule
